// File: rtl/os_ctrl_pkg.sv
// os_ctrl_pkg: shared types and constants for the OS/PC controller slice.
package os_ctrl_pkg;
  typedef enum logic {USER = 1'b0, KERNEL = 1'b1} state_e;
  localparam int unsigned QUANTUM_DEFAULT = 10;
  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] SO_ENTRY_ADDR = 32'd17;
endpackage

// File: rtl/quantum_counter_sat_counter.sv
// sat_counter: unsigned up-counter that clears on clr and sticks at MAX.
module sat_counter #(
  parameter int unsigned COUNT_W = 5,
  parameter int unsigned MAX = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] cnt
);
  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX);
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  // Equality on MAX guarantees the downstream "== MAX" compare is observed.
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != MAX_C) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/quantum_counter.sv
// quantum_counter: counts user instructions per quantum, tracks USER/KERNEL, latches preempted PC.
// Optional QUANTUM_SWITCH_STATS_EN adds switch_count and a self-preemption assertion.
module quantum_counter
  import os_ctrl_pkg::*;
#(
  parameter int unsigned QUANTUM = QUANTUM_DEFAULT,
  parameter int unsigned COUNT_W = 5,
  parameter logic [PC_W-1:0] SO_ENTRY = SO_ENTRY_ADDR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  input  logic [PC_W-1:0]    pc_curr,
  input  logic               enable_so,
  input  logic               so_return,
  output logic [COUNT_W-1:0] pc_counter,
  output logic               kernel_mode,
  output logic [PC_W-1:0]    saved_pc,
  output logic               saved_valid,
  output logic [15:0]        switch_count
);
  if (QUANTUM >= (1 << COUNT_W)) $error("QUANTUM must fit in COUNT_W bits");
  if (SO_ENTRY == '0) $error("SO_ENTRY must differ from the saved_pc reset value");
  state_e state_q, state_d;
  logic [PC_W-1:0] saved_pc_q, saved_pc_d;
  logic saved_valid_q, saved_valid_d;
  logic preempt, resume, in_kernel;
  always_comb begin
    in_kernel = state_q == KERNEL;
    preempt = !in_kernel && enable_so;
    resume = in_kernel && so_return;
    state_d = preempt ? KERNEL : resume ? USER : state_q;
    saved_pc_d = preempt ? pc_curr : saved_pc_q;
    saved_valid_d = preempt ? 1'b1 : resume ? 1'b0 : saved_valid_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= USER;
      saved_pc_q <= '0;
      saved_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_pc_q <= saved_pc_d;
      saved_valid_q <= saved_valid_d;
    end
  end
  // Kernel holds the count at zero; a preempting instruction is not counted.
  sat_counter #(.COUNT_W(COUNT_W), .MAX(QUANTUM)) u_cnt (
    .clk(clock),
    .rst(reset),
    .inc(!in_kernel && instr_valid && !enable_so),
    .clr(preempt || in_kernel),
    .cnt(pc_counter)
  );
  assign kernel_mode = state_q == KERNEL;
  assign saved_pc = saved_pc_q;
  assign saved_valid = saved_valid_q;
`ifdef QUANTUM_SWITCH_STATS_EN
  logic [15:0] switch_q, switch_d;
  always_comb switch_d = preempt ? switch_q + 16'd1 : switch_q;
  always_ff @(posedge clock) begin
    switch_q <= reset ? 16'd0 : switch_d;
    if (!reset && preempt) assert (pc_curr != SO_ENTRY) else $error("OS preempted itself at SO_ENTRY");
  end
  assign switch_count = switch_q;
`else
  assign switch_count = 16'd0;
`endif
endmodule

// File: tb/tb_quantum_counter.sv
// tb_quantum_counter: directed vectors checked every cycle against a behavioural model plus literal pins.
module tb_quantum_counter;
  logic clock = 1'b0;
  logic reset = 1'b1, instr_valid = 1'b0, enable_so = 1'b0, so_return = 1'b0;
  logic [31:0] pc_curr = '0;
  logic [4:0] pc_counter;
  logic kernel_mode, saved_valid;
  logic [31:0] saved_pc;
  logic [15:0] switch_count;
  int checks = 0, failures = 0;
  bit model_ok = 0, m_kernel = 0, m_valid = 0;
  int unsigned m_cnt = 0, m_sw = 0;
  logic [31:0] m_saved = '0;
  quantum_counter dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .pc_curr(pc_curr),
    .enable_so(enable_so), .so_return(so_return), .pc_counter(pc_counter),
    .kernel_mode(kernel_mode), .saved_pc(saved_pc), .saved_valid(saved_valid),
    .switch_count(switch_count)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (reset) begin
      model_ok = 1; m_kernel = 0; m_valid = 0; m_cnt = 0; m_sw = 0; m_saved = '0;
    end else if (!m_kernel) begin
      if (enable_so) begin
        m_kernel = 1; m_saved = pc_curr; m_valid = 1; m_cnt = 0; m_sw = (m_sw + 1) % 65536;
      end else if (instr_valid && m_cnt < 10) m_cnt = m_cnt + 1;
    end else if (so_return) begin
      m_kernel = 0; m_valid = 0;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clock) if (model_ok) begin
    chk("pc_counter", 32'(pc_counter), m_cnt);
    chk("kernel_mode", 32'(kernel_mode), 32'(m_kernel));
    chk("saved_pc", saved_pc, m_saved);
    chk("saved_valid", 32'(saved_valid), 32'(m_valid));
`ifdef QUANTUM_SWITCH_STATS_EN
    chk("switch_count", 32'(switch_count), m_sw);
`else
    chk("switch_count", 32'(switch_count), 32'd0);
`endif
  end
  task automatic cyc(input logic r, input logic iv, input logic es, input logic sr, input logic [31:0] pc);
    @(negedge clock);
    #1;
    reset = r; instr_valid = iv; enable_so = es; so_return = sr; pc_curr = pc;
    @(posedge clock);
    #2;
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_cnt", 32'(pc_counter), 32'd0);
    chk("rst_kernel", 32'(kernel_mode), 32'd0);
    chk("rst_saved", saved_pc, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 0, 0, 32'h20);
      chk("count_step", 32'(pc_counter), i);
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 32'h20);
    chk("saturate", 32'(pc_counter), 32'd10);
    chk("user_mode", 32'(kernel_mode), 32'd0);
    cyc(0, 0, 1, 0, 32'h40);
    chk("pre_kernel", 32'(kernel_mode), 32'd1);
    chk("pre_saved", saved_pc, 32'h40);
    chk("pre_valid", 32'(saved_valid), 32'd1);
    chk("pre_cnt", 32'(pc_counter), 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 32'h99);
    chk("kern_cnt", 32'(pc_counter), 32'd0);
    chk("kern_saved", saved_pc, 32'h40);
    cyc(0, 0, 1, 1, 32'h99);
    chk("ret_kernel", 32'(kernel_mode), 32'd0);
    chk("ret_valid", 32'(saved_valid), 32'd0);
    chk("ret_cnt", 32'(pc_counter), 32'd0);
    chk("ret_saved_kept", saved_pc, 32'h40);
    cyc(0, 0, 0, 1, 32'h99);
    chk("user_ignores_ret", 32'(kernel_mode), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 32'h50);
    chk("cnt4", 32'(pc_counter), 32'd4);
    cyc(0, 1, 1, 0, 32'h80);
    chk("prio_kernel", 32'(kernel_mode), 32'd1);
    chk("prio_cnt", 32'(pc_counter), 32'd0);
    chk("prio_saved", saved_pc, 32'h80);
    cyc(0, 0, 0, 1, 32'h0);
    cyc(0, 0, 1, 0, 32'h40);
    cyc(1, 1, 1, 0, 32'h40);
    chk("krst_kernel", 32'(kernel_mode), 32'd0);
    chk("krst_saved", saved_pc, 32'd0);
    chk("krst_valid", 32'(saved_valid), 32'd0);
    chk("krst_cnt", 32'(pc_counter), 32'd0);
    chk("krst_sw", 32'(switch_count), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 0, 32'h100);
      cyc(0, 0, 1, 0, 32'h100 + k);
      cyc(0, 0, 0, 1, 32'h0);
    end
    chk("cycles_saved", saved_pc, 32'h102);
`ifdef QUANTUM_SWITCH_STATS_EN
    chk("switch3", 32'(switch_count), 32'd3);
`else
    chk("switch0", 32'(switch_count), 32'd0);
`endif
    cyc(0, 0, 0, 0, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
